// File: rtl/fixed_to_float_pipe.sv
// ============================================================================
// fixed_to_float_pipe
// ----------------------------------------------------------------------------
// Converts a sign-magnitude fixed-point value (value = mag * 2^-FIXED_FRACTIONAL)
// into an IEEE-754 single-precision word. This is the return path from the
// fixed-point collision datapath back towards the float host side.
//
// Three register stages:
//   1. capture sign / magnitude, flag zero magnitude
//   2. leading-one detect and left-normalise the magnitude
//   3. pack exponent and truncated mantissa into float_out
//
// The whole pipeline advances together when the output register is empty or
// is being drained, so a stall at the output freezes every stage. Bubbles are
// carried through as invalid slots and are never collapsed.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-high, clears all pipeline state
//   in_valid    fixed_sign / fixed_mag hold a sample
//   in_ready    block accepts a sample this cycle (combinational)
//   fixed_sign  1 = negative
//   fixed_mag   unsigned magnitude, FIXED_WIDTH bits
//   out_valid   float_out holds a result
//   out_ready   downstream accepts float_out this cycle
//   float_out   {sign, exp[7:0], mantissa[22:0]}
//   busy        OR of all stage valid bits
// ============================================================================
module fixed_to_float_pipe #(
    parameter int FIXED_WIDTH      = 32,
    parameter int FIXED_FRACTIONAL = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   fixed_sign,
    input  logic [FIXED_WIDTH-1:0] fixed_mag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            float_out,
    output logic                   busy
);

    localparam int PW = $clog2(FIXED_WIDTH);

    // Index of the most significant set bit; 0 for an all-zero input (the
    // zero case is handled separately by the zero flag).
    function automatic logic [PW-1:0] msb_index(input logic [FIXED_WIDTH-1:0] v);
        logic [PW-1:0] idx;
        idx = {PW{1'b0}};
        for (int i = 0; i < FIXED_WIDTH; i++) begin
            idx = v[i] ? PW'(i) : idx;
        end
        return idx;
    endfunction

    // Pipeline control
    logic                   advance_s;

    // Stage 1 registers
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_sign_q,  s1_sign_d;
    logic                   s1_zero_q,  s1_zero_d;
    logic [FIXED_WIDTH-1:0] s1_mag_q,   s1_mag_d;

    // Stage 2 registers
    logic                   s2_valid_q, s2_valid_d;
    logic                   s2_sign_q,  s2_sign_d;
    logic                   s2_zero_q,  s2_zero_d;
    logic [PW-1:0]          s2_msb_q,   s2_msb_d;
    logic [FIXED_WIDTH-1:0] s2_norm_q,  s2_norm_d;

    // Stage 3 (output) registers
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            float_q,     float_d;

    // Stage 2 / stage 3 combinational intermediates
    logic [PW-1:0]          msb_s;
    logic [PW-1:0]          lzc_s;
    logic [FIXED_WIDTH-1:0] norm_s;
    logic [8:0]             exp_s;
    logic [FIXED_WIDTH+21:0] frac_ext_s;
    logic [22:0]            mant_s;
    logic [31:0]            pack_s;

    // Global advance: output empty or being drained.
    always_comb begin
        advance_s = !out_valid_q || out_ready;
    end

    // Stage 1 next state: capture the input (valid or bubble) on advance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_mag_d   = s1_mag_q;
        if (advance_s) begin
            s1_valid_d = in_valid;
            s1_sign_d  = fixed_sign;
            s1_zero_d  = (fixed_mag == {FIXED_WIDTH{1'b0}});
            s1_mag_d   = fixed_mag;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 datapath: leading-one position and left normalisation.
    always_comb begin
        msb_s  = msb_index(s1_mag_q);
        lzc_s  = PW'(FIXED_WIDTH - 1) - msb_s;
        norm_s = s1_mag_q << lzc_s;
    end

    // Stage 2 next state.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_msb_d   = s2_msb_q;
        s2_norm_d  = s2_norm_q;
        if (advance_s) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = s1_zero_q;
            s2_msb_d   = msb_s;
            s2_norm_d  = norm_s;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 3 datapath: biased exponent and truncated mantissa. The implicit
    // leading one (norm MSB) is dropped; remaining bits are left-aligned into
    // 23 bits with zero fill, no rounding.
    always_comb begin
        exp_s      = 9'd127 + {{(9 - PW){1'b0}}, s2_msb_q} - 9'(FIXED_FRACTIONAL);
        frac_ext_s = {s2_norm_q[FIXED_WIDTH-2:0], 23'b0};
        mant_s     = frac_ext_s[FIXED_WIDTH+21 -: 23];
        if (s2_zero_q) begin
            pack_s = 32'h0000_0000;
        end else begin
            pack_s = {s2_sign_q, exp_s[7:0], mant_s};
        end
    end

    // Stage 3 next state; float_out only changes when a real result lands so
    // bubbles do not disturb the last value.
    always_comb begin
        out_valid_d = out_valid_q;
        float_d     = float_q;
        if (advance_s) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                float_d = pack_s;
            end else begin
                float_d = float_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_mag_q    <= {FIXED_WIDTH{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_msb_q    <= {PW{1'b0}};
            s2_norm_q   <= {FIXED_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            float_q     <= 32'h0000_0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_msb_q    <= s2_msb_d;
            s2_norm_q   <= s2_norm_d;
            out_valid_q <= out_valid_d;
            float_q     <= float_d;
        end
    end

    // Output drive.
    always_comb begin
        in_ready  = advance_s;
        out_valid = out_valid_q;
        float_out = float_q;
        busy      = s1_valid_q || s2_valid_q || out_valid_q;
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// ============================================================================
// tb_fixed_to_float_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for fixed_to_float_pipe (32-bit magnitude, 16 fractional
// bits). Inputs are driven on the falling edge; outputs are observed 1 ns
// later. Every accepted sample is converted by a reference model that works
// from the numeric value (power-of-two search and integer division) and its
// result is queued; every drained output is compared against the queue head.
// ============================================================================
module tb_fixed_to_float_pipe;

    localparam int FW   = 32;
    localparam int FRAC = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          fixed_sign;
    logic [FW-1:0] fixed_mag;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   float_out;
    logic          busy;

    fixed_to_float_pipe #(
        .FIXED_WIDTH      (FW),
        .FIXED_FRACTIONAL (FRAC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fixed_sign (fixed_sign),
        .fixed_mag  (fixed_mag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .float_out  (float_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_float = 32'h0;

    // Count one comparison and report it if it does not hold.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: value = mag * 2^-FRAC; find e with 2^e <= mag < 2^(e+1),
    // mantissa = floor(mag * 2^23 / 2^e) - 2^23, biased exponent e-FRAC+127.
    function automatic logic [31:0] ref_float(input logic sg, input logic [31:0] mg);
        longint unsigned m;
        longint unsigned mant;
        int              e;
        logic [7:0]      ef;
        if (mg == 32'd0) return 32'h0000_0000;
        m = 64'(mg);
        e = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'd1 << k) <= m) e = k;
        end
        mant = (m * (64'd1 << 23)) / (64'd1 << e) - (64'd1 << 23);
        ef   = 8'(e - FRAC + 127);
        return {sg, ef, mant[22:0]};
    endfunction

    // One clock: drive on the falling edge, observe, and account for the
    // transfers that the next rising edge will perform.
    task automatic cycle(input logic iv, input logic sg, input logic [31:0] mg, input logic ordy);
        @(negedge clk);
        in_valid   = iv;
        fixed_sign = sg;
        fixed_mag  = mg;
        out_ready  = ordy;
        #1;
        if (prev_stall) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", float_out, prev_float);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else                   check("data", float_out, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_float(sg, mg));
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_float = float_out;
    endtask

    // Single sample with latency and constant-value check.
    task automatic directed(input string tag, input logic sg, input logic [31:0] mg, input logic [31:0] expv);
        logic early;
        early = 1'b0;
        cycle(1'b1, sg, mg, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        early = early | out_valid;
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        early = early | out_valid;
        check({tag, "_early"}, {31'b0, early}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check(tag, float_out, expv);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ov[16];
        int          first, run, idx, stall_left, base_out, base_acc, guard;
        logic        stalled_once;
        logic [31:0] bp_mag[5];
        logic [31:0] mg;

        reset      = 1'b1;
        in_valid   = 1'b0;
        fixed_sign = 1'b0;
        fixed_mag  = 32'd0;
        out_ready  = 1'b0;
        #23;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_float", float_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed values
        directed("one",     1'b0, 32'h0001_0000, 32'h3F80_0000);
        directed("neg_1p5", 1'b1, 32'h0001_8000, 32'hBFC0_0000);
        directed("min",     1'b0, 32'h0000_0001, 32'h3780_0000);
        directed("max",     1'b0, 32'hFFFF_FFFF, 32'h477F_FFFF);
        directed("neg_zero",1'b1, 32'h0000_0000, 32'h0000_0000);

        // Streaming: 8 back-to-back samples
        for (int i = 0; i < 16; i++) begin
            cycle(i < 8, 1'($urandom_range(0, 1)), $urandom, 1'b1);
            if (i < 8) check("stream_ready", {31'b0, in_ready}, 32'd1);
            ov[i] = out_valid;
        end
        first = -1;
        run   = 0;
        for (int i = 0; i < 16; i++) begin
            if (ov[i] && first < 0) first = i;
        end
        if (first >= 0) begin
            for (int i = first; i < 16 && ov[i]; i++) run++;
        end
        check("stream_run", 32'(run), 32'd8);

        // Backpressure: 5 samples, 4-cycle stall once results appear
        for (int i = 0; i < 5; i++) bp_mag[i] = $urandom;
        idx          = 0;
        stall_left   = 0;
        stalled_once = 1'b0;
        base_out     = n_out;
        guard        = 0;
        while ((n_out - base_out) < 5 && guard < 60) begin
            guard++;
            if (!stalled_once && out_valid) begin
                stalled_once = 1'b1;
                stall_left   = 4;
            end
            base_acc = n_acc;
            cycle(idx < 5, 1'(idx & 1), (idx < 5) ? bp_mag[idx] : 32'd0, stall_left == 0);
            if (stall_left > 0) begin
                check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                stall_left--;
            end
            if (n_acc != base_acc) idx++;
        end
        check("bp_count", 32'(n_out - base_out), 32'd5);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0001_0000 << i, 1'b1);
        @(negedge clk);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end

        // Random traffic with input gaps and random output stalls
        base_acc = n_acc;
        guard    = 0;
        while ((n_acc - base_acc) < 10000 && guard < 40000) begin
            guard++;
            if ($urandom_range(0, 9) == 0) mg = 32'd0;
            else                           mg = $urandom >> $urandom_range(0, 31);
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), mg,
                  $urandom_range(0, 3) != 0);
        end
        check("rand_accepted", 32'(n_acc - base_acc), 32'd10000);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            guard++;
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("idle_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
